periph_bus_sequencer: RTL and testbench

//  Sequences CPU-side register accesses onto NPORT peripheral-port blocks sharing one N-bit data bus.

---
 rtl/periph_bus_pkg.sv | 22 ++
 rtl/periph_onehot_dec.sv | 19 +
 rtl/periph_bus_sequencer.sv | 115 +++++++++++
 tb/tb_periph_bus_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus sequencer.
package periph_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RESP,
        TURN
    } state_t;

    localparam logic [1:0] REG_OUT = 2'd0;
    localparam logic [1:0] REG_DIR = 2'd1;
    localparam logic [1:0] REG_IN  = 2'd2;

    // Register-level legality: OUT/DIR are write-only, IN is read-only, 3 is reserved.
    function automatic logic access_illegal(input logic write, input logic [1:0] sel);
        if (write) return !(sel == REG_OUT || sel == REG_DIR);
        return sel != REG_IN;
    endfunction

endpackage

// File: rtl/periph_onehot_dec.sv
// Binary port index plus enable to one-hot port strobe vector.
module periph_onehot_dec #(
    parameter int NPORT = 4,
    parameter int PW    = 2
) (
    input  logic [PW-1:0]    idx,
    input  logic             en,
    output logic [NPORT-1:0] onehot
);

    // NOTE: combinational outputs get a full default first so no latch can be inferred.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NPORT; i++) begin
            onehot[i] = en && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/periph_bus_sequencer.sv
// Sequences CPU register accesses onto shared-bus peripheral ports.
// Optional PERIPH_BUS_TURNAROUND_EN inserts an idle TURN cycle after each read.
module periph_bus_sequencer
    import periph_bus_pkg::*;
#(
    parameter int N     = 64,
    parameter int NPORT = 4,
    parameter int PW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [PW-1:0]    req_port,
    input  logic [1:0]       req_reg,
    input  logic [N-1:0]     req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_rdata,
    output logic             rsp_err,
    output logic             bus_drive,
    output logic [N-1:0]     bus_wdata,
    input  logic [N-1:0]     bus_rdata,
    output logic [NPORT-1:0] read_in,
    output logic [NPORT-1:0] load_out,
    output logic [NPORT-1:0] load_dir
);

    state_t          state, state_next;
    logic            lat_write;
    logic [PW-1:0]   lat_port;
    logic [1:0]      lat_reg;
    logic [N-1:0]    lat_wdata;
    logic            lat_err;
    logic            accept;
    logic            req_err;

    assign accept  = req_valid && req_ready;
    assign req_err = access_illegal(req_write, req_reg) || (int'(req_port) >= NPORT);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = req_err ? RESP : SETUP;
            SETUP:  state_next = STROBE;
            STROBE: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
`ifdef PERIPH_BUS_TURNAROUND_EN
                    state_next = lat_write ? IDLE : TURN;
`else
                    state_next = IDLE;
`endif
                end
            end
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rsp_rdata only changes on the transition into RESP, so it holds between responses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_write <= 1'b0;
            lat_port  <= '0;
            lat_reg   <= '0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_port  <= req_port;
                lat_reg   <= req_reg;
                lat_wdata <= req_wdata;
                lat_err   <= req_err;
                if (req_err) rsp_rdata <= '0;
            end
            if (state == STROBE) rsp_rdata <= lat_write ? '0 : bus_rdata;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && lat_err;
    assign bus_drive = lat_write && (state == SETUP || state == STROBE);
    assign bus_wdata = bus_drive ? lat_wdata : '0;

    // Reads never enable the controller drive, so read_in and bus_drive are exclusive.
    periph_onehot_dec #(.NPORT(NPORT), .PW(PW)) u_dec_read_in (
        .idx    (lat_port),
        .en     (!lat_write && (state == SETUP || state == STROBE)),
        .onehot (read_in)
    );

    periph_onehot_dec #(.NPORT(NPORT), .PW(PW)) u_dec_load_out (
        .idx    (lat_port),
        .en     (lat_write && state == STROBE && lat_reg == REG_OUT),
        .onehot (load_out)
    );

    periph_onehot_dec #(.NPORT(NPORT), .PW(PW)) u_dec_load_dir (
        .idx    (lat_port),
        .en     (lat_write && state == STROBE && lat_reg == REG_DIR),
        .onehot (load_dir)
    );

endmodule

// File: tb/tb_periph_bus_sequencer.sv
// Directed self-checking bench for periph_bus_sequencer (NPORT=4, PW=3 so port 4 is expressible).
module tb_periph_bus_sequencer;

    localparam int N     = 64;
    localparam int NPORT = 4;
    localparam int PW    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [PW-1:0]    req_port;
    logic [1:0]       req_reg;
    logic [N-1:0]     req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_rdata;
    logic             rsp_err;
    logic             bus_drive;
    logic [N-1:0]     bus_wdata;
    logic [N-1:0]     bus_rdata;
    logic [NPORT-1:0] read_in;
    logic [NPORT-1:0] load_out;
    logic [NPORT-1:0] load_dir;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    periph_bus_sequencer #(.N(N), .NPORT(NPORT), .PW(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_port  (req_port),
        .req_reg   (req_reg),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_drive (bus_drive),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .read_in   (read_in),
        .load_out  (load_out),
        .load_dir  (load_dir)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one cycle; returns sampled in the cycle after acceptance.
    task automatic issue(input logic w, input logic [PW-1:0] p, input logic [1:0] r,
                         input logic [63:0] d);
        req_write = w;
        req_port  = p;
        req_reg   = r;
        req_wdata = d;
        req_valid = 1'b1;
        check("accept_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_resp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("back_idle_ready", req_ready, 1);
        check("back_idle_rsp_valid", rsp_valid, 0);
    endtask

    task automatic check_no_strobe(input string tag);
        check(tag, {read_in, load_out, load_dir}, 0);
    endtask

    // Bus contention and strobe exclusivity are watched on every falling edge.
    always @(negedge clock) begin
        check("no_contention", bus_drive && (|read_in), 0);
        check("strobe_onehot",
              ($countones(read_in) + $countones(load_out) + $countones(load_dir)) <= 1, 1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_port  = '0;
        req_reg   = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        bus_rdata = '0;

        // Reset values
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_bus_drive", bus_drive, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check_no_strobe("rst_strobes");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Write port1 OUT = A5A5
        issue(1'b1, 3'd1, 2'd0, 64'hA5A5);
        check("wr_out_setup_drive", bus_drive, 1);
        check("wr_out_setup_wdata", bus_wdata, 64'hA5A5);
        check_no_strobe("wr_out_setup_strobes");
        check("wr_out_setup_ready", req_ready, 0);
        step();
        check("wr_out_strobe_drive", bus_drive, 1);
        check("wr_out_strobe_wdata", bus_wdata, 64'hA5A5);
        check("wr_out_load_out", load_out, 4'b0010);
        check("wr_out_load_dir", load_dir, 0);
        check("wr_out_read_in", read_in, 0);
        step();
        check("wr_out_rsp_valid", rsp_valid, 1);
        check("wr_out_rsp_err", rsp_err, 0);
        check("wr_out_rsp_rdata", rsp_rdata, 0);
        check("wr_out_resp_drive", bus_drive, 0);
        check_no_strobe("wr_out_resp_strobes");
        finish_resp();

        // Write port3 DIR = FF, rsp_ready raised before RESP is entered
        issue(1'b1, 3'd3, 2'd1, 64'hFF);
        check_no_strobe("wr_dir_setup_strobes");
        check("wr_dir_setup_wdata", bus_wdata, 64'hFF);
        step();
        check("wr_dir_load_dir", load_dir, 4'b1000);
        check("wr_dir_load_out", load_out, 0);
        check("wr_dir_read_in", read_in, 0);
        rsp_ready = 1'b1;
        step();
        check("wr_dir_rsp_valid", rsp_valid, 1);
        check_no_strobe("wr_dir_resp_strobes");
        step();
        rsp_ready = 1'b0;
        check("wr_dir_same_cycle_ack", rsp_valid, 0);
        check("wr_dir_idle_ready", req_ready, 1);

        // Read port2 IN with bus = 1234, then hold the response 5 cycles
        bus_rdata = 64'h1234;
        issue(1'b0, 3'd2, 2'd2, 64'h0);
        check("rd_setup_read_in", read_in, 4'b0100);
        check("rd_setup_drive", bus_drive, 0);
        step();
        check("rd_strobe_read_in", read_in, 4'b0100);
        check("rd_strobe_drive", bus_drive, 0);
        check("rd_strobe_load", {load_out, load_dir}, 0);
        step();
        bus_rdata = 64'h9999;
        for (int i = 0; i < 5; i++) begin
            check("rd_hold_rsp_valid", rsp_valid, 1);
            check("rd_hold_rdata", rsp_rdata, 64'h1234);
            check("rd_hold_err", rsp_err, 0);
            check("rd_hold_req_ready", req_ready, 0);
            check_no_strobe("rd_hold_strobes");
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rd_done_rsp_valid", rsp_valid, 0);
        check("rd_done_rdata_held", rsp_rdata, 64'h1234);
`ifdef PERIPH_BUS_TURNAROUND_EN
        check("rd_turn_ready", req_ready, 0);
        step();
`endif
        check("rd_idle_ready", req_ready, 1);

        // Illegal: reserved register
        issue(1'b1, 3'd0, 2'd3, 64'h55);
        check("err_rsv_rsp_valid", rsp_valid, 1);
        check("err_rsv_rsp_err", rsp_err, 1);
        check("err_rsv_rdata", rsp_rdata, 0);
        check("err_rsv_drive", bus_drive, 0);
        check_no_strobe("err_rsv_strobes");
        finish_resp();

        // Illegal: write to IN
        issue(1'b1, 3'd1, 2'd2, 64'h77);
        check("err_wrin_rsp_valid", rsp_valid, 1);
        check("err_wrin_rsp_err", rsp_err, 1);
        check("err_wrin_drive", bus_drive, 0);
        check_no_strobe("err_wrin_strobes");
        finish_resp();

        // Illegal: port 4 with NPORT = 4
        issue(1'b1, 3'd4, 2'd0, 64'h11);
        check("err_port_rsp_valid", rsp_valid, 1);
        check("err_port_rsp_err", rsp_err, 1);
        check("err_port_drive", bus_drive, 0);
        check_no_strobe("err_port_strobes");
        finish_resp();

        // Illegal: read of OUT
        issue(1'b0, 3'd0, 2'd0, 64'h0);
        check("err_rdout_rsp_err", rsp_err, 1);
        check_no_strobe("err_rdout_strobes");
        finish_resp();
        check("err_cleared", rsp_err, 0);

        // Reset asserted during STROBE
        issue(1'b1, 3'd0, 2'd0, 64'hBEEF);
        step();
        check("rst_mid_load_out", load_out, 4'b0001);
        check("rst_mid_drive", bus_drive, 1);
        #2;
        reset = 1'b1;
        #1;
        check_no_strobe("rst_mid_strobes_low");
        check("rst_mid_drive_low", bus_drive, 0);
        check("rst_mid_wdata_low", bus_wdata, 0);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        check("rst_after_rsp_valid", rsp_valid, 0);
        check("rst_after_ready", req_ready, 1);

        // Sequencer is usable again after the abandoned access
        issue(1'b1, 3'd2, 2'd1, 64'h3C);
        step();
        check("post_rst_load_dir", load_dir, 4'b0100);
        step();
        check("post_rst_rsp_valid", rsp_valid, 1);
        finish_resp();

        #4;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
